mem_access_stage: RTL

- Pipeline MEM stage. Consumes the EX/MEM register contents (ALU result or address, store data, funct3, control bits) and drives the data-memory handshake.
- Performs byte-lane steering for stores and sign/zero extension for loads.
- Registers the MEM/WB outputs for writeback.
- Stalls the upstream pipeline while a data-memory access is outstanding.

---
 rtl/mem_access_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with data-memory handshake, store lane steering and load extension.
// Optional build macro MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES cycles without dmem_ack.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [31:0] ex_alu_data,
    input  logic [31:0] ex_store_data,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [31:0] wb_alu_data,
    output logic [31:0] wb_mem_data,
    output logic        mem_err,
    output logic        o_dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t      r_state;
    logic [29:0] r_addr;
    logic [1:0]  r_off;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic [31:0] r_alu;

    logic        w_is_mem;
    logic        w_f3_ok;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_accept;
    logic        w_in_access;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW   = (CLOG > 8) ? CLOG : 8;
    logic [CW-1:0] r_cnt;
    // Fires on the TIMEOUT_CYCLES-th ACCESS cycle; an ack in that cycle still wins in the FSM.
    assign w_timeout = w_in_access && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_is_mem = ex_mem_read | ex_mem_write;
        if (ex_mem_write) begin
            w_f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            w_f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        w_misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_data[0]) ||
                       ((ex_funct3[1:0] == 2'b10) && (ex_alu_data[1:0] != 2'b00));
        w_illegal    = (ex_mem_read & ex_mem_write) | ~w_f3_ok | w_misaligned;
        w_in_access  = (r_state == S_ACCESS);
        w_accept     = (r_state == S_IDLE) && ex_valid && w_is_mem && !w_illegal;
    end

    // Handshake: stall_out is the inverse of ready. The EX/MEM entry is consumed on the first
    // cycle with ex_valid=1 and stall_out=0; while stall_out=1 upstream holds all ex_* stable.
    assign stall_out = w_accept | (w_in_access & ~dmem_ack & ~w_timeout);

    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ex_alu_data[1:0];
                w_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = ex_alu_data[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ex_store_data;
            end
        endcase
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_off         <= '0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_rd          <= '0;
            r_funct3      <= '0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_alu         <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_alu_data   <= '0;
            wb_mem_data   <= '0;
            mem_err       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt         <= '0;
`endif
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!w_is_mem || w_illegal) begin
                            // Pass-through, or an illegal access that is reported instead of issued.
                            wb_valid      <= 1'b1;
                            wb_rd         <= ex_rd;
                            wb_reg_write  <= ex_reg_write & ~w_is_mem;
                            wb_mem_to_reg <= ex_mem_to_reg;
                            wb_alu_data   <= ex_alu_data;
                            wb_mem_data   <= '0;
                            mem_err       <= w_is_mem;
                        end else begin
                            r_state      <= S_ACCESS;
                            r_addr       <= ex_alu_data[31:2];
                            r_off        <= ex_alu_data[1:0];
                            r_be         <= w_be;
                            r_wdata      <= w_wdata;
                            r_we         <= ex_mem_write;
                            r_rd         <= ex_rd;
                            r_funct3     <= ex_funct3;
                            r_reg_write  <= ex_reg_write;
                            r_mem_to_reg <= ex_mem_to_reg;
                            r_alu        <= ex_alu_data;
`ifdef MEM_TIMEOUT_EN
                            r_cnt        <= '0;
`endif
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        r_state       <= S_IDLE;
                        wb_valid      <= 1'b1;
                        wb_rd         <= r_rd;
                        wb_reg_write  <= r_reg_write & ~r_we;
                        wb_mem_to_reg <= r_mem_to_reg;
                        wb_alu_data   <= r_alu;
                        wb_mem_data   <= r_we ? 32'h0 : w_load_data;
                    end else if (w_timeout) begin
                        r_state       <= S_IDLE;
                        wb_valid      <= 1'b1;
                        wb_rd         <= r_rd;
                        wb_reg_write  <= 1'b0;
                        wb_mem_to_reg <= r_mem_to_reg;
                        wb_alu_data   <= r_alu;
                        wb_mem_data   <= '0;
                        mem_err       <= 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign dmem_req    = w_in_access;
    assign dmem_we     = r_we;
    assign dmem_addr   = {r_addr, 2'b00};
    assign dmem_wdata  = r_wdata;
    assign dmem_be     = r_be;
    assign o_dbg_state = r_state;

endmodule
